// File: rtl/sub_nbit_signed_serial.sv
// Bit-serial signed subtractor: diff = A - B computed LSB first as A + ~B + 1,
// one bit per clock behind a start/busy/done handshake.
//
// state   | meaning
// S_IDLE  | waiting for start; operands captured on accept
// S_SHIFT | one full-adder bit step per cycle, W steps total
// S_DONE  | single-cycle completion, done high
module sub_nbit_signed_serial #(
    parameter int DATA_WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH:0]   A,
    input  logic signed [DATA_WIDTH:0]   B,
    output logic                         busy,
    output logic                         done,
    output logic signed [DATA_WIDTH+1:0] diff
);

    localparam int W  = DATA_WIDTH + 2;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_sr;
    logic [W-1:0]   nb_sr;
    logic [W-1:0]   res_sr;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           sum_bit;
    logic           carry_nxt;

    always_comb begin
        sum_bit   = a_sr[0] ^ nb_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & nb_sr[0]) | (a_sr[0] & carry) | (nb_sr[0] & carry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            nb_sr  <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Carry-in of 1 plus inverted B turns the adder into A - B.
                        a_sr  <= {A[DATA_WIDTH], A};
                        nb_sr <= ~{B[DATA_WIDTH], B};
                        carry <= 1'b1;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr   <= {1'b0, a_sr[W-1:1]};
                    nb_sr  <= {1'b0, nb_sr[W-1:1]};
                    res_sr <= {sum_bit, res_sr[W-1:1]};
                    carry  <= carry_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        diff  <= {sum_bit, res_sr[W-1:1]};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
